pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: cache-miss hold, branch flush/redirect and load-use stall.
// Optional stall counter output is enabled by defining HAZARD_STALL_COUNT_EN.
module pipeline_hazard_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        hit,
    input  logic        memReadEx,
    input  logic [4:0]  rtEx,
    input  logic [4:0]  rsId,
    input  logic [4:0]  rtId,
    input  logic        branchTaken,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        exmemFlush,
    output logic        idexHit,
    output logic [1:0]  state
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0] stallCount
`endif
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMiss     = 2'd1,
        StRedirect = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   pend_flush_q, pend_flush_d;
    logic   load_use;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = memReadEx && (rtEx != 5'd0) && ((rtEx == rsId) || (rtEx == rtId));

    always_comb begin
        pcWrite      = 1'b0;
        ifidWrite    = 1'b0;
        ifidFlush    = 1'b0;
        idexFlush    = 1'b0;
        exmemFlush   = 1'b0;
        idexHit      = 1'b0;
        state_d      = StRun;
        pend_flush_d = pend_flush_q;

        if (RST) begin
            ifidFlush    = 1'b1;
            idexFlush    = 1'b1;
            exmemFlush   = 1'b1;
            idexHit      = 1'b1;
            pend_flush_d = 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (!hit) begin
                        state_d      = StMiss;
                        pend_flush_d = branchTaken;
                    end else if (branchTaken) begin
                        pcWrite    = 1'b1;
                        ifidWrite  = 1'b1;
                        ifidFlush  = 1'b1;
                        idexFlush  = 1'b1;
                        exmemFlush = 1'b1;
                        idexHit    = 1'b1;
                    end else if (load_use) begin
                        idexFlush = 1'b1;
                        idexHit   = 1'b1;
                    end else begin
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                        idexHit   = 1'b1;
                    end
                end
                StMiss: begin
                    // A branch seen while frozen is remembered and replayed as a redirect.
                    if (!hit) begin
                        state_d      = StMiss;
                        pend_flush_d = pend_flush_q | branchTaken;
                    end else begin
                        state_d      = (pend_flush_q | branchTaken) ? StRedirect : StRun;
                        pend_flush_d = 1'b0;
                    end
                end
                StRedirect: begin
                    if (!hit) begin
                        state_d      = StMiss;
                        pend_flush_d = branchTaken;
                    end else begin
                        pcWrite    = 1'b1;
                        ifidWrite  = 1'b1;
                        ifidFlush  = 1'b1;
                        idexFlush  = 1'b1;
                        exmemFlush = 1'b1;
                        idexHit    = 1'b1;
                    end
                end
                default: begin
                    state_d      = StRun;
                    pend_flush_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StRun;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    assign state = state_q;

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_count_q <= 32'd0;
        end else if (!pcWrite) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stallCount = stall_count_q;
`endif

endmodule
